// File: rtl/l1_missq_trace_replayer.sv
// rtl/l1_missq_trace_replayer.sv - replays buffered L1 miss-trace records as stamp-timed requests
module l1_missq_trace_replayer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             rec_valid,
    output logic             rec_ready,
    input  logic             rec_eof,
    input  logic [38:0]      rec_pc,
    input  logic [3:0]       rec_source,
    input  logic [35:0]      rec_paddr,
    input  logic [38:0]      rec_vaddr,
    input  logic [63:0]      rec_stamp,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [38:0]      req_pc,
    output logic [3:0]       req_source,
    output logic [35:0]      req_paddr,
    output logic [38:0]      req_vaddr,
    output logic             busy,
    output logic             done,
    output logic             order_err,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] late_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [38:0] mem_pc     [DEPTH];
    logic [3:0]  mem_source [DEPTH];
    logic [35:0] mem_paddr  [DEPTH];
    logic [38:0] mem_vaddr  [DEPTH];
    logic [63:0] mem_stamp  [DEPTH];

    logic [AW:0]  wr_ptr, rd_ptr, count;
    logic [63:0]  elapsed, last_stamp, head_stamp;
    logic         eof_seen;
    logic         empty, full, active;
    logic         push, hs, stop_hit, start_hit, drain_empty;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count      = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_stamp = mem_stamp[rd_ptr[AW-1:0]];

    assign active    = (state == S_RUN) || (state == S_DRAIN);
    assign stop_hit  = active && stop;
    assign start_hit = ((state == S_IDLE) || (state == S_DONE)) && start;

    assign rec_ready = !full && (state != S_DONE);
    assign push      = rec_valid && rec_ready;

    // Head becomes eligible the same cycle elapsed reaches its stamp.
    assign req_valid  = active && !empty && (head_stamp <= elapsed);
    assign hs         = req_valid && req_ready;
    assign req_pc     = mem_pc[rd_ptr[AW-1:0]];
    assign req_source = mem_source[rd_ptr[AW-1:0]];
    assign req_paddr  = mem_paddr[rd_ptr[AW-1:0]];
    assign req_vaddr  = mem_vaddr[rd_ptr[AW-1:0]];

    // FIFO ends up empty once this cycle's pop retires the last entry and nothing new arrives.
    assign drain_empty = !push && (count == {{AW{1'b0}}, hs});

    assign busy = active;
    assign done = (state == S_DONE);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; stop outranks every other event in RUN/DRAIN.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN: begin
                if (stop)                      state_nxt = S_IDLE;
                else if (eof_seen || rec_eof)  state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (stop)             state_nxt = S_IDLE;
                else if (drain_empty) state_nxt = S_DONE;
            end
            S_DONE:  if (start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Record storage; cleared on reset so the head fields read zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]     <= '0;
                mem_source[i] <= '0;
                mem_paddr[i]  <= '0;
                mem_vaddr[i]  <= '0;
                mem_stamp[i]  <= '0;
            end
        end else if (push) begin
            mem_pc[wr_ptr[AW-1:0]]     <= rec_pc;
            mem_source[wr_ptr[AW-1:0]] <= rec_source;
            mem_paddr[wr_ptr[AW-1:0]]  <= rec_paddr;
            mem_vaddr[wr_ptr[AW-1:0]]  <= rec_vaddr;
            mem_stamp[wr_ptr[AW-1:0]]  <= rec_stamp;
        end
    end

    // FIFO pointers; stop discards everything, including a same-cycle push.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (stop_hit) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (hs)   rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Replay clock: restarts at zero on start, advances only while replaying, freezes on stop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                     elapsed <= '0;
        else if (start_hit)             elapsed <= '0;
        else if (active && !stop_hit)   elapsed <= elapsed + 64'd1;
    end

    // Issue statistics and stamp-ordering check, updated on each accepted request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            issued_cnt <= '0;
            late_cnt   <= '0;
            order_err  <= 1'b0;
            last_stamp <= '0;
        end else if (start_hit) begin
            issued_cnt <= '0;
            late_cnt   <= '0;
            order_err  <= 1'b0;
            last_stamp <= '0;
        end else if (hs) begin
            if (issued_cnt != CNT_MAX)
                issued_cnt <= issued_cnt + CNT_ONE;
            if ((elapsed > head_stamp) && (late_cnt != CNT_MAX))
                late_cnt <= late_cnt + CNT_ONE;
            if (head_stamp < last_stamp)
                order_err <= 1'b1;
            last_stamp <= head_stamp;
        end
    end

    // End-of-trace marker; an eof arriving with start survives the restart.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                              eof_seen <= 1'b0;
        else if (start_hit)                      eof_seen <= rec_eof;
        else if (rec_eof && (state != S_DONE))   eof_seen <= 1'b1;
    end

endmodule

// File: tb/tb_l1_missq_trace_replayer.sv
// tb/tb_l1_missq_trace_replayer.sv - randomized and directed checks against a queue-based replay model
module tb_l1_missq_trace_replayer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int unsigned SAT = (1 << CNT_W) - 1;

    logic             clock, reset, start, stop;
    logic             rec_valid, rec_ready, rec_eof;
    logic [38:0]      rec_pc;
    logic [3:0]       rec_source;
    logic [35:0]      rec_paddr;
    logic [38:0]      rec_vaddr;
    logic [63:0]      rec_stamp;
    logic             req_valid, req_ready;
    logic [38:0]      req_pc;
    logic [3:0]       req_source;
    logic [35:0]      req_paddr;
    logic [38:0]      req_vaddr;
    logic             busy, done, order_err;
    logic [CNT_W-1:0] issued_cnt, late_cnt;

    l1_missq_trace_replayer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_eof(rec_eof),
        .rec_pc(rec_pc), .rec_source(rec_source), .rec_paddr(rec_paddr),
        .rec_vaddr(rec_vaddr), .rec_stamp(rec_stamp),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_pc(req_pc), .req_source(req_source), .req_paddr(req_paddr),
        .req_vaddr(req_vaddr), .busy(busy), .done(done), .order_err(order_err),
        .issued_cnt(issued_cnt), .late_cnt(late_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [38:0] pc;
        logic [3:0]  source;
        logic [35:0] paddr;
        logic [38:0] vaddr;
        logic [63:0] stamp;
    } rec_t;

    // Reference model: a record queue plus replay flags and statistics.
    rec_t        mq[$];
    bit          m_run, m_drain, m_fin, m_eof, m_oerr;
    logic [63:0] m_el, m_last;
    int unsigned m_iss, m_late;
    int          run_cyc;
    int          obs_log[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_run = 0; m_drain = 0; m_fin = 0; m_eof = 0; m_oerr = 0;
        m_el = '0; m_last = '0; m_iss = 0; m_late = 0;
        run_cyc = 0;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; rec_valid = 0; rec_eof = 0;
    endtask

    task automatic set_rec(input logic [63:0] stamp);
        rec_pc     = 39'({$urandom(), $urandom()});
        rec_source = 4'($urandom());
        rec_paddr  = 36'({$urandom(), $urandom()});
        rec_vaddr  = 39'({$urandom(), $urandom()});
        rec_stamp  = stamp;
    endtask

    function automatic bit exp_rec_ready();
        return (mq.size() < DEPTH) && !m_fin;
    endfunction

    // One clock: compare outputs against the model, then advance the model with the applied inputs.
    task automatic cycle();
        bit   e_rr, e_rv, push, hs, was_fin;
        rec_t r;
        #1;
        e_rr = exp_rec_ready();
        e_rv = m_run && (mq.size() > 0) && (mq[0].stamp <= m_el);
        chk("rec_ready", 64'(rec_ready), 64'(e_rr));
        chk("req_valid", 64'(req_valid), 64'(e_rv));
        if (e_rv) begin
            chk("req_pc",     64'(req_pc),     64'(mq[0].pc));
            chk("req_source", 64'(req_source), 64'(mq[0].source));
            chk("req_paddr",  64'(req_paddr),  64'(mq[0].paddr));
            chk("req_vaddr",  64'(req_vaddr),  64'(mq[0].vaddr));
        end
        chk("busy",       64'(busy),       64'(m_run));
        chk("done",       64'(done),       64'(m_fin));
        chk("order_err",  64'(order_err),  64'(m_oerr));
        chk("issued_cnt", 64'(issued_cnt), 64'(m_iss));
        chk("late_cnt",   64'(late_cnt),   64'(m_late));
        if (req_valid && req_ready) obs_log.push_back(run_cyc);
        @(posedge clock);
        push    = rec_valid && e_rr;
        hs      = e_rv && req_ready;
        was_fin = m_fin;
        if (hs) begin
            if (m_iss < SAT) m_iss++;
            if ((m_el > mq[0].stamp) && (m_late < SAT)) m_late++;
            if (mq[0].stamp < m_last) m_oerr = 1;
            m_last = mq[0].stamp;
            void'(mq.pop_front());
        end
        if (push) begin
            r.pc = rec_pc; r.source = rec_source; r.paddr = rec_paddr;
            r.vaddr = rec_vaddr; r.stamp = rec_stamp;
            mq.push_back(r);
        end
        run_cyc++;
        if (m_run && stop) begin
            mq.delete();
            m_run = 0; m_drain = 0;
            if (rec_eof) m_eof = 1;
        end else begin
            if (m_run) m_el = m_el + 64'd1;
            if (!was_fin && rec_eof) m_eof = 1;
            if (!m_run && start) begin
                m_run = 1; m_drain = 0; m_fin = 0;
                m_el = '0; m_last = '0; m_iss = 0; m_late = 0; m_oerr = 0;
                m_eof = rec_eof;
                run_cyc = 0;
            end else if (m_run && !m_drain && m_eof) begin
                m_drain = 1;
            end else if (m_drain && (mq.size() == 0)) begin
                m_run = 0; m_drain = 0; m_fin = 1;
            end
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        idle_inputs();
        req_ready = 0;
        set_rec(64'd0);
        reset = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 1;
        model_reset();
    endtask

    task automatic preload(input logic [63:0] stamp);
        set_rec(stamp);
        rec_valid = 1;
        cycle();
        rec_valid = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        cycle();
        start = 0;
        obs_log.delete();
    endtask

    int exp_at[3];
    int idx, done_at;
    bit acc;

    initial begin
        reset = 0;
        idle_inputs();
        req_ready = 0;
        set_rec(64'd0);
        model_reset();
        do_reset();

        // Reset state.
        #1;
        chk("rst_rec_ready", 64'(rec_ready), 64'd1);
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_done",      64'(done),      64'd0);
        chk("rst_issued",    64'(issued_cnt), 64'd0);
        @(negedge clock);

        // Stamps 0,5,5 preloaded in IDLE issue at elapsed 0,5,6.
        preload(64'd0); preload(64'd5); preload(64'd5);
        pulse_start();
        req_ready = 1;
        repeat (10) cycle();
        exp_at[0] = 0; exp_at[1] = 5; exp_at[2] = 6;
        chk("t1_n_issue", 64'(obs_log.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            chk("t1_issue_at", 64'((i < obs_log.size()) ? obs_log[i] : -1), 64'(exp_at[i]));
        chk("t1_issued", 64'(issued_cnt), 64'd3);
        chk("t1_late",   64'(late_cnt),   64'd1);

        // Backwards stamps flag order_err but both still issue.
        do_reset();
        preload(64'd2); preload(64'd1);
        pulse_start();
        req_ready = 1;
        repeat (8) cycle();
        chk("t2_order_err", 64'(order_err), 64'd1);
        chk("t2_issued",    64'(issued_cnt), 64'd2);

        // Full FIFO back-pressures the source, then drains in order.
        do_reset();
        pulse_start();
        req_ready = 0;
        for (int i = 0; i < 4; i++) begin
            set_rec(64'(i)); rec_valid = 1; cycle();
        end
        rec_valid = 0;
        #1;
        chk("t3_full_ready", 64'(rec_ready), 64'd0);
        @(negedge clock);
        idx = 4;
        req_ready = 1;
        for (int n = 0; n < 20; n++) begin
            rec_valid = (idx < 6);
            if (idx < 6) set_rec(64'(idx));
            acc = rec_valid && exp_rec_ready();
            cycle();
            if (acc) idx++;
        end
        rec_valid = 0;
        chk("t3_all_pushed", 64'(idx), 64'd6);
        chk("t3_issued",     64'(issued_cnt), 64'd6);

        // eof with the second record: DRAIN, then DONE one cycle after the last handshake.
        do_reset();
        pulse_start();
        req_ready = 1;
        set_rec(64'd0); rec_valid = 1; cycle();
        set_rec(64'd0); rec_eof = 1; cycle();
        rec_valid = 0; rec_eof = 0;
        done_at = -1;
        for (int n = 0; n < 8; n++) begin
            if (done && (done_at < 0)) done_at = run_cyc;
            cycle();
        end
        chk("t4_n_issue", 64'(obs_log.size()), 64'd2);
        chk("t4_done_at", 64'(done_at), 64'((obs_log.size() > 0) ? obs_log[obs_log.size()-1] + 1 : -2));
        #1;
        chk("t4_done",      64'(done),      64'd1);
        chk("t4_busy",      64'(busy),      64'd0);
        chk("t4_rec_ready", 64'(rec_ready), 64'd0);
        @(negedge clock);
        pulse_start();
        #1;
        chk("t4_restart_busy",   64'(busy),       64'd1);
        chk("t4_restart_issued", 64'(issued_cnt), 64'd0);
        @(negedge clock);

        // stop with a same-cycle handshake: it counts, FIFO flushed, back to IDLE.
        do_reset();
        preload(64'd0); preload(64'd0);
        pulse_start();
        req_ready = 1; stop = 1;
        cycle();
        stop = 0;
        #1;
        chk("t5_issued",    64'(issued_cnt), 64'd1);
        chk("t5_busy",      64'(busy),       64'd0);
        chk("t5_req_valid", 64'(req_valid),  64'd0);
        @(negedge clock);
        pulse_start();
        repeat (4) cycle();
        chk("t5_flushed_issued", 64'(issued_cnt), 64'd0);

        // Reset asserted mid-stall drops the request immediately.
        do_reset();
        preload(64'd0); preload(64'd0);
        pulse_start();
        req_ready = 1; cycle();
        req_ready = 0; cycle(); cycle();
        reset = 0;
        #1;
        chk("t6_req_valid", 64'(req_valid),  64'd0);
        chk("t6_issued",    64'(issued_cnt), 64'd0);
        chk("t6_rec_ready", 64'(rec_ready),  64'd1);
        chk("t6_busy",      64'(busy),       64'd0);
        @(negedge clock);
        reset = 1;
        model_reset();

        // Randomized traffic, including counter saturation and stop/start churn.
        for (int n = 0; n < 2500; n++) begin
            rec_valid = ($urandom_range(0, 1) == 1);
            set_rec(64'($urandom_range(0, 60)));
            req_ready = ($urandom_range(0, 9) < 7);
            start     = ($urandom_range(0, 15) == 0);
            stop      = ($urandom_range(0, 99) == 0);
            rec_eof   = ($urandom_range(0, 59) == 0);
            cycle();
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
